// File: rtl/idt_clk_prog.sv
// Serial programming controller for the IDT clock synthesizer:
// shifts a 24-bit word out over SCLK/DATA, strobes it, then waits for PLL settling.
module idt_clk_prog #(
    parameter int          DIV           = 5,
    parameter int          STROBE_CYCLES = 10,
    parameter int          SETTLE_CYCLES = 100000,
    parameter bit          AUTO_START    = 1'b1,
    parameter logic [23:0] INIT_WORD     = 24'h000000
) (
    input  logic        osc_clk,
    input  logic        osc_reset_,
    input  logic        cfg_valid,
    input  logic [23:0] cfg_word,
    output logic        cfg_ready,
    output logic        busy,
    output logic        done,
    output logic [23:0] cur_word,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe
);

    localparam int M1   = (DIV > STROBE_CYCLES) ? DIV : STROBE_CYCLES;
    localparam int MAXC = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DIV_LD = CW'(DIV - 1);
    localparam logic [CW-1:0] STB_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);
    // Auto-start holds SHIFT_LO one extra cycle so the reset period acts as T0.
    localparam logic [CW-1:0] RST_CNT = AUTO_START ? CW'(DIV) : '0;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        STROBE,
        SETTLE
    } state_t;

    localparam state_t RST_ST = AUTO_START ? SHIFT_LO : IDLE;
    localparam logic   RST_DATA = AUTO_START ? INIT_WORD[23] : 1'b0;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [23:0]   shift;
    logic [23:0]   word;
    logic [4:0]    bitcnt;

    assign busy      = (state != IDLE);
    assign cfg_ready = (state == IDLE);

    always_ff @(posedge osc_clk or negedge osc_reset_) begin
        if (!osc_reset_) begin
            state      <= RST_ST;
            cnt        <= RST_CNT;
            shift      <= INIT_WORD;
            word       <= INIT_WORD;
            bitcnt     <= '0;
            cur_word   <= '0;
            done       <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= RST_DATA;
            idt_strobe <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        state    <= SHIFT_LO;
                        cnt      <= DIV_LD;
                        shift    <= cfg_word;
                        word     <= cfg_word;
                        bitcnt   <= '0;
                        idt_sclk <= 1'b0;
                        idt_data <= cfg_word[23];
                    end
                end
                SHIFT_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state    <= SHIFT_HI;
                        cnt      <= DIV_LD;
                        idt_sclk <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (bitcnt == 5'd23) begin
                        state      <= STROBE;
                        cnt        <= STB_LD;
                        idt_sclk   <= 1'b0;
                        idt_data   <= 1'b0;
                        idt_strobe <= 1'b1;
                        cur_word   <= word;
                    end else begin
                        state    <= SHIFT_LO;
                        cnt      <= DIV_LD;
                        shift    <= {shift[22:0], 1'b0};
                        bitcnt   <= bitcnt + 1'b1;
                        idt_sclk <= 1'b0;
                        idt_data <= shift[22];
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= SETTLE;
                        cnt        <= SET_LD;
                        idt_strobe <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idt_clk_prog.sv
// Bench for idt_clk_prog: cycle-offset model of the serial protocol
// checked every cycle, plus hand-computed timing points.
module tb_idt_clk_prog;

    typedef struct packed {
        logic sclk;
        logic data;
        logic strobe;
        logic done;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b0, rst1 = 1'b0;
    logic        v0 = 1'b0, v2 = 1'b0;
    logic        v1;
    logic [23:0] w0 = '0, w1, w2 = '0;

    logic        rdy0, busy0, done0, sclk0, data0, stb0;
    logic        rdy1, busy1, done1, sclk1, data1, stb1;
    logic        rdy2, busy2, done2, sclk2, data2, stb2;
    logic [23:0] cur0, cur1, cur2;

    assign v1 = 1'b0;
    assign w1 = 24'h0;

    idt_clk_prog #(.DIV(2), .STROBE_CYCLES(4), .SETTLE_CYCLES(10),
                   .AUTO_START(1'b0), .INIT_WORD(24'h0)) u0 (
        .osc_clk(clk), .osc_reset_(rst0), .cfg_valid(v0), .cfg_word(w0),
        .cfg_ready(rdy0), .busy(busy0), .done(done0), .cur_word(cur0),
        .idt_sclk(sclk0), .idt_data(data0), .idt_strobe(stb0));

    idt_clk_prog #(.DIV(2), .STROBE_CYCLES(4), .SETTLE_CYCLES(10),
                   .AUTO_START(1'b1), .INIT_WORD(24'h123456)) u1 (
        .osc_clk(clk), .osc_reset_(rst1), .cfg_valid(v1), .cfg_word(w1),
        .cfg_ready(rdy1), .busy(busy1), .done(done1), .cur_word(cur1),
        .idt_sclk(sclk1), .idt_data(data1), .idt_strobe(stb1));

    idt_clk_prog #(.DIV(1), .STROBE_CYCLES(4), .SETTLE_CYCLES(10),
                   .AUTO_START(1'b0), .INIT_WORD(24'h0)) u2 (
        .osc_clk(clk), .osc_reset_(rst0), .cfg_valid(v2), .cfg_word(w2),
        .cfg_ready(rdy2), .busy(busy2), .done(done2), .cur_word(cur2),
        .idt_sclk(sclk2), .idt_data(data2), .idt_strobe(stb2));

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, x);
        end
    endtask

    // Expected outputs at cycle offset 'off' after the accept (T0).
    function automatic exp_t model(input int d, input int s, input int q,
                                   input int off, input logic [23:0] w);
        exp_t e;
        int   sh;
        e  = '0;
        sh = 48 * d;
        if (off >= 1 && off <= sh) begin
            e.sclk = (((off - 1) / d) % 2) == 1;
            e.data = w[23 - (off - 1) / (2 * d)];
            e.busy = 1'b1;
        end else if (off > sh && off <= sh + s) begin
            e.strobe = 1'b1;
            e.busy   = 1'b1;
        end else if (off > sh + s && off <= sh + s + q) begin
            e.busy = 1'b1;
        end else if (off == sh + s + q + 1) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    // Transaction-level model of u0.
    int          t0 = -1;
    logic [23:0] mword = '0;
    logic [23:0] mcur = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst0) begin
            t0   = -1;
            mcur = '0;
        end else begin
            if (t0 >= 0 && cyc - t0 == 97) mcur = mword;
            if (v0 && (t0 < 0 || cyc - 1 - t0 >= 111)) begin
                t0    = cyc - 1;
                mword = w0;
            end
        end
    end

    int          nr0 = 0, nr1 = 0, nr2 = 0;
    logic [23:0] s0 = '0, s1 = '0, s2 = '0;
    int          rc0 [0:511];
    int          nsb0 = 0, nd0 = 0;
    int          sc0 [0:511];
    int          dc0 [0:511];

    always @(posedge sclk0) begin
        if (nr0 < 512) rc0[nr0] = cyc;
        s0 = {s0[22:0], data0};
        nr0++;
    end

    always @(posedge sclk1) begin
        s1 = {s1[22:0], data1};
        nr1++;
    end

    always @(posedge sclk2) begin
        s2 = {s2[22:0], data2};
        nr2++;
    end

    always @(negedge clk) begin
        exp_t e;
        int   off;
        if (rst0) begin
            off = (t0 < 0) ? -1 : cyc - t0;
            e   = model(2, 4, 10, off, mword);
            chk("u0 sclk", 32'(sclk0), 32'(e.sclk));
            chk("u0 data", 32'(data0), 32'(e.data));
            chk("u0 strobe", 32'(stb0), 32'(e.strobe));
            chk("u0 done", 32'(done0), 32'(e.done));
            chk("u0 busy", 32'(busy0), 32'(e.busy));
            chk("u0 ready", 32'(rdy0), 32'(!e.busy));
            chk("u0 cur", 32'(cur0), 32'(mcur));
            if (stb0) begin
                if (nsb0 < 512) sc0[nsb0] = cyc;
                nsb0++;
            end
            if (done0) begin
                if (nd0 < 512) dc0[nd0] = cyc;
                nd0++;
            end
        end
    end

    initial begin
        int   T0, T1, br, bs, bd, off, dcyc;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst sclk", 32'(sclk0), 32'h0);
        chk("rst data", 32'(data0), 32'h0);
        chk("rst strobe", 32'(stb0), 32'h0);
        chk("rst busy", 32'(busy0), 32'h0);
        chk("rst ready", 32'(rdy0), 32'h1);
        chk("rst cur", 32'(cur0), 32'h0);
        chk("auto rst busy", 32'(busy1), 32'h1);
        chk("auto rst ready", 32'(rdy1), 32'h0);
        chk("auto rst sclk", 32'(sclk1), 32'h0);
        chk("auto rst data", 32'(data1), 32'h0);
        rst0 = 1'b1;
        @(negedge clk);

        // Test 1: basic programming
        br = nr0; bs = nsb0; bd = nd0;
        v0 = 1'b1; w0 = 24'hA5C3F0; T0 = cyc;
        @(negedge clk);
        v0 = 1'b0;
        repeat (115) @(negedge clk);
        chk("t1 rises", 32'(nr0 - br), 32'd24);
        chk("t1 stream", 32'(s0), 32'hA5C3F0);
        chk("t1 first rise", 32'(rc0[br] - T0), 32'd3);
        chk("t1 strobe start", 32'(sc0[bs] - T0), 32'd97);
        chk("t1 strobe len", 32'(nsb0 - bs), 32'd4);
        chk("t1 strobe end", 32'(sc0[bs + 3] - T0), 32'd100);
        chk("t1 done", 32'(dc0[bd] - T0), 32'd111);
        chk("t1 cur", 32'(cur0), 32'hA5C3F0);

        // Test 3: request during transfer is dropped
        br = nr0; bd = nd0;
        v0 = 1'b1; w0 = 24'h0F1E2D; T0 = cyc;
        @(negedge clk);
        v0 = 1'b0;
        repeat (19) @(negedge clk);
        v0 = 1'b1; w0 = 24'hFFFFFF;
        @(negedge clk);
        v0 = 1'b0;
        repeat (200) @(negedge clk);
        chk("t3 rises", 32'(nr0 - br), 32'd24);
        chk("t3 stream", 32'(s0), 32'h0F1E2D);
        chk("t3 cur", 32'(cur0), 32'h0F1E2D);
        chk("t3 dones", 32'(nd0 - bd), 32'd1);
        chk("t3 done", 32'(dc0[bd] - T0), 32'd111);

        // Test 4: request held across done is taken in the done cycle
        br = nr0; bd = nd0;
        v0 = 1'b1; w0 = 24'hC0FFEE; T0 = cyc;
        @(negedge clk);
        w0 = 24'h000001;
        repeat (110) @(negedge clk);
        T1 = cyc;
        @(negedge clk);
        v0 = 1'b0;
        repeat (115) @(negedge clk);
        chk("t4 done a", 32'(dc0[bd] - T0), 32'd111);
        chk("t4 done b", 32'(dc0[bd + 1] - T0), 32'd222);
        chk("t4 rises", 32'(nr0 - br), 32'd48);
        chk("t4 rise b", 32'(rc0[br + 24] - T1), 32'd3);
        chk("t4 stream", 32'(s0), 32'h000001);
        chk("t4 cur", 32'(cur0), 32'h000001);

        // Test 5: reset mid-shift
        bs = nsb0;
        v0 = 1'b1; w0 = 24'h5A5A5A;
        @(negedge clk);
        v0 = 1'b0;
        repeat (49) @(negedge clk);
        rst0 = 1'b0;
        #1;
        chk("t5 sclk", 32'(sclk0), 32'h0);
        chk("t5 data", 32'(data0), 32'h0);
        chk("t5 strobe", 32'(stb0), 32'h0);
        chk("t5 cur", 32'(cur0), 32'h0);
        chk("t5 busy", 32'(busy0), 32'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        chk("t5 ready", 32'(rdy0), 32'h1);
        repeat (120) @(negedge clk);
        chk("t5 no strobe", 32'(nsb0 - bs), 32'd0);
        chk("t5 cur idle", 32'(cur0), 32'h0);

        // Test 2: auto-start after reset release
        rst1 = 1'b1; T1 = cyc;
        for (int i = 0; i < 114; i++) begin
            @(negedge clk);
            off = cyc - T1;
            e = model(2, 4, 10, off, 24'h123456);
            chk("u1 sclk", 32'(sclk1), 32'(e.sclk));
            chk("u1 data", 32'(data1), 32'(e.data));
            chk("u1 strobe", 32'(stb1), 32'(e.strobe));
            chk("u1 done", 32'(done1), 32'(e.done));
            chk("u1 busy", 32'(busy1), 32'(e.busy));
            chk("u1 ready", 32'(rdy1), 32'(!e.busy));
            chk("u1 cur", 32'(cur1),
                (off >= 97) ? 32'h123456 : 32'h0);
        end
        chk("t2 rises", 32'(nr1), 32'd24);
        chk("t2 stream", 32'(s1), 32'h123456);

        // Test 6: DIV=1
        v2 = 1'b1; w2 = 24'h96E1B4; T0 = cyc; dcyc = -1;
        @(negedge clk);
        v2 = 1'b0;
        for (int i = 0; i < 66; i++) begin
            off = cyc - T0;
            e = model(1, 4, 10, off, 24'h96E1B4);
            chk("u2 sclk", 32'(sclk2), 32'(e.sclk));
            chk("u2 data", 32'(data2), 32'(e.data));
            chk("u2 strobe", 32'(stb2), 32'(e.strobe));
            chk("u2 done", 32'(done2), 32'(e.done));
            chk("u2 busy", 32'(busy2), 32'(e.busy));
            chk("u2 ready", 32'(rdy2), 32'(!e.busy));
            chk("u2 cur", 32'(cur2),
                (off >= 49) ? 32'h96E1B4 : 32'h0);
            if (done2) dcyc = cyc;
            @(negedge clk);
        end
        chk("t6 rises", 32'(nr2), 32'd24);
        chk("t6 stream", 32'(s2), 32'h96E1B4);
        chk("t6 done", 32'(dcyc - T0), 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
